// File: rtl/riscv_pc_unit.sv
// Program counter with target selection, misalignment trap and a circular
// return-address stack used only as a prediction hint for returns.
module riscv_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = 'h100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            misalign
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    SRC_PLUS4 = 2'd0,
    SRC_JAL   = 2'd1,
    SRC_JALR  = 2'd2,
    SRC_RSVD  = 2'd3
  } pc_src_e;

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;    // next free slot; top entry sits at r_ptr-1
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic [PW-1:0]   w_top_idx;
  logic            w_ras_upd;
  logic            w_ras_we;
  logic [PW-1:0]   w_ras_waddr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_empty;

  assign w_pc_plus4   = r_pc + XLEN'(4);
  assign w_top_idx    = r_ptr - PW'(1);
  assign w_empty      = (r_count == '0);
  assign w_misaligned = w_target[1];
  assign w_ras_upd    = ~stall & ~w_misaligned;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_target = w_pc_plus4;
    unique case (pc_src_e'(pc_src))
      SRC_JAL:  w_target = r_pc + imm;
      SRC_JALR: w_target = (rs1 + imm) & ~XLEN'(1);
      default:  w_target = w_pc_plus4;
    endcase
  end

  // Push, pop or replace-top; a coroutine call on an empty stack degrades to a push.
  always_comb begin
    w_ras_we    = 1'b0;
    w_ras_waddr = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    if (w_ras_upd) begin
      if ((is_call && !is_ret) || (is_call && is_ret && w_empty)) begin
        w_ras_we    = 1'b1;
        w_ras_waddr = r_ptr;
        w_ptr_nxt   = r_ptr + PW'(1);
        w_count_nxt = (r_count == FULL) ? r_count : r_count + CW'(1);
      end else if (is_call && is_ret) begin
        w_ras_we    = 1'b1;
        w_ras_waddr = w_top_idx;
      end else if (is_ret && !w_empty) begin
        w_ptr_nxt   = w_top_idx;
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else if (!stall) begin
      r_pc       <= w_misaligned ? TRAP_PC : w_target;
      r_misalign <= w_misaligned;
      r_ptr      <= w_ptr_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // NOTE: the stack storage is left unreset; entries are only visible through r_count, which is reset.
  always_ff @(posedge clk) begin
    if (w_ras_we && rst) begin
      r_ras[w_ras_waddr] <= w_pc_plus4;
    end
  end

  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign misalign  = r_misalign;
  assign ras_valid = ~w_empty;
  assign ras_top   = w_empty ? '0 : r_ras[w_top_idx];

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Scoreboard bench for riscv_pc_unit: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_riscv_pc_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] TRAP_PC   = 32'h100;
  localparam int          RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        is_call = 1'b0;
  logic        is_ret = 1'b0;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, misalign;

  riscv_pc_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .imm(imm), .rs1(rs1),
    .is_call(is_call), .is_ret(is_ret), .pc(pc), .pc_plus4(pc_plus4),
    .ras_top(ras_top), .ras_valid(ras_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] top;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
    m_ras.delete();
  endfunction

  // Reference behaviour: plain arithmetic on the PC and a bounded queue for the stack.
  function automatic void model_step(input logic s, input logic [1:0] src,
                                     input logic [31:0] im, input logic [31:0] r1,
                                     input logic c, input logic rt);
    logic [31:0] t;
    logic [31:0] ret_addr;
    if (s) return;
    ret_addr = m_pc + 32'd4;
    case (src)
      2'd1:    t = m_pc + im;
      2'd2:    t = (r1 + im) & 32'hFFFF_FFFE;
      default: t = m_pc + 32'd4;
    endcase
    if (((t >> 1) & 32'd1) != 0) begin
      m_pc  = TRAP_PC;
      m_mis = 1'b1;
      return;
    end
    m_pc  = t;
    m_mis = 1'b0;
    if (c && !rt) begin
      m_ras.push_back(ret_addr);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (rt && !c) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end else if (c && rt) begin
      if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret_addr;
      else m_ras.push_back(ret_addr);
    end
  endfunction

  task automatic step(input logic s, input logic [1:0] src, input logic [31:0] im,
                      input logic [31:0] r1, input logic c, input logic rt);
    exp_t e;
    stall = s; pc_src = src; imm = im; rs1 = r1; is_call = c; is_ret = rt;
    model_step(s, src, im, r1, c, rt);
    @(posedge clk);
    e.pc    = m_pc;
    e.top   = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    e.valid = (m_ras.size() > 0);
    e.mis   = m_mis;
    sb.push_back(e);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},        pc,        RESET_PC);
    check({tag, "_misalign"},  {31'b0, misalign},  32'd0);
    check({tag, "_ras_valid"}, {31'b0, ras_valid}, 32'd0);
    check({tag, "_ras_top"},   ras_top,   32'd0);
  endtask

  // Assert reset between clock edges and confirm it acts without a clock edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_state(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc",        pc,                 e.pc);
        check("pc_plus4",  pc_plus4,           e.pc + 32'd4);
        check("ras_top",   ras_top,            e.top);
        check("ras_valid", {31'b0, ras_valid}, {31'b0, e.valid});
        check("misalign",  {31'b0, misalign},  {31'b0, e.mis});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  src;
    logic [31:0] im, r1;
    model_reset();
    #2 check_reset_state("por");
    @(negedge clk);
    rst = 1'b1;

    // Forward jump, sequential fetch, backward jump.
    step(0, 2'd1, 32'd12, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 2'd0, 0, 0, 0, 0);
    step(0, 2'd1, -32'sd8, 0, 0, 0);
    @(negedge clk);
    check("fwd_jump_pc", pc, 32'd20);

    // Self-jump holds pc at zero.
    apply_reset("rst_self");
    for (int i = 0; i < 5; i++) step(0, 2'd1, 32'd0, 0, 0, 0);

    // Misaligned branch target traps and pulses misalign once.
    apply_reset("rst_mis");
    step(0, 2'd1, 32'd4, 0, 1, 0);
    step(0, 2'd1, 32'd6, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 0);
    step(0, 2'd2, 32'd3, 32'h40, 0, 0);
    step(0, 2'd0, 0, 0, 0, 0);

    // Stack overflow wraps and pops drain to empty.
    apply_reset("rst_ovf");
    for (int i = 0; i < 5; i++) step(0, 2'd1, 32'd8, 0, 1, 0);
    @(negedge clk);
    check("ovf_top", ras_top, 32'd36);
    for (int i = 0; i < 5; i++) step(0, 2'd0, 0, 0, 0, 1);
    step(0, 2'd0, 0, 0, 0, 1);

    // Coroutine replace-top, then stall holds everything.
    apply_reset("rst_co");
    step(0, 2'd0, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 1, 1);
    @(negedge clk);
    check("co_top", ras_top, 32'd8);
    for (int i = 0; i < 3; i++) step(1, 2'd1, 32'd40, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 1);
    step(0, 2'd0, 0, 0, 1, 1);

    // Stall right after a misalign pulse holds it.
    step(0, 2'd1, 32'd2, 0, 0, 0);
    step(1, 2'd1, 32'd2, 0, 0, 0);
    step(0, 2'd0, 0, 0, 0, 0);

    // Async reset mid-operation with two entries on the stack.
    apply_reset("rst_async_pre");
    step(0, 2'd1, 32'd12, 0, 1, 0);
    step(0, 2'd0, 0, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0, 0);
    apply_reset("async");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      src = 2'($urandom_range(0, 3));
      im  = $urandom;
      r1  = $urandom;
      if ($urandom_range(0, 4) != 0) im = im & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) != 0) r1 = r1 & 32'hFFFF_FFFC;
      step(($urandom_range(0, 5) == 0), src, im, r1,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if (i == 200) apply_reset("rst_rand");
    end

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
